// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: FSM encodings and datapath width default.
// Latency: none (declarations only).
// Backpressure: n/a.
package adder_arb_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_arb_rr_picker.sv
// Round-robin picker: first asserted request after i_last_grant, scanning upward with wrap.
// Latency: purely combinational.
// Backpressure: none; o_any=0 when no request is pending.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int               w_cand;
  logic [IDX_W-1:0] w_cand_idx;

  // Scan last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); the first hit wins.
  always_comb begin
    o_grant    = '0;
    o_idx      = '0;
    o_any      = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand     = (int'(i_last_grant) + off) % NUM_REQ;
      w_cand_idx = IDX_W'(w_cand);
      if (!o_any && i_req[w_cand_idx]) begin
        o_any               = 1'b1;
        o_grant[w_cand_idx] = 1'b1;
        o_idx               = w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one combinational adder among NUM_REQ requesters; ADDER_ARB_STATS_EN builds grant_count.
// Latency: handshake edge N, registered operands in CALC, resp_valid one-hot pulse during cycle N+2; 1 txn / 3 cycles.
// Backpressure: req_ready only in IDLE (held requests wait); results have no backpressure and last one cycle.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = WIDTH_DEF,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opr1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opr2,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [IDX_W-1:0]           resp_id,
  output logic [WIDTH-1:0]           resp_ans,
  output logic                       resp_carry,
  output logic [WIDTH-1:0]           adder_opr1,
  output logic [WIDTH-1:0]           adder_opr2,
  input  logic [WIDTH-1:0]           adder_ans,
  input  logic                       adder_carry,
  output logic [31:0]                grant_count
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [WIDTH-1:0]   r_adder_opr1;
  logic [WIDTH-1:0]   r_adder_opr2;
  logic [IDX_W-1:0]   r_resp_id;
  logic [WIDTH-1:0]   r_resp_ans;
  logic               r_resp_carry;
  logic [NUM_REQ-1:0] r_resp_valid;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_idx        (w_idx),
    .o_any        (w_any)
  );

  // Ready is offered only in IDLE and is held low while reset is asserted,
  // so no requester can believe it was accepted during reset.
  assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
  assign w_accept  = (r_state == IDLE) && w_any;

  // Transaction FSM: latch winner in IDLE, capture adder result in CALC, strobe in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_adder_opr1 <= '0;
      r_adder_opr2 <= '0;
      r_resp_id    <= '0;
      r_resp_ans   <= '0;
      r_resp_carry <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_valid <= '0;
          if (w_accept) begin
            r_adder_opr1 <= req_opr1[w_idx*WIDTH +: WIDTH];
            r_adder_opr2 <= req_opr2[w_idx*WIDTH +: WIDTH];
            r_resp_id    <= w_idx;
            r_last_grant <= w_idx;
            r_state      <= CALC;
          end
        end
        CALC: begin
          r_resp_ans   <= adder_ans;
          r_resp_carry <= adder_carry;
          r_resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_resp_id;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_valid <= '0;
          r_state      <= IDLE;
        end
        default: begin
          r_resp_valid <= '0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign adder_opr1 = r_adder_opr1;
  assign adder_opr2 = r_adder_opr2;
  assign resp_id    = r_resp_id;
  assign resp_ans   = r_resp_ans;
  assign resp_carry = r_resp_carry;
  assign resp_valid = r_resp_valid;

`ifdef ADDER_ARB_STATS_EN
  logic [31:0] r_grant_count;

  // Count accepted handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_count <= 32'h0;
    end else if (w_accept) begin
      r_grant_count <= r_grant_count + 32'h1;
    end
  end

  assign grant_count = r_grant_count;
`else
  assign grant_count = 32'h0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural model of the shared adder.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;

`ifdef ADDER_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_opr1;
  logic [NUM_REQ*WIDTH-1:0] req_opr2;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [1:0]               resp_id;
  logic [WIDTH-1:0]         resp_ans;
  logic                     resp_carry;
  logic [WIDTH-1:0]         adder_opr1;
  logic [WIDTH-1:0]         adder_opr2;
  logic [WIDTH-1:0]         adder_ans;
  logic                     adder_carry;
  logic [31:0]              grant_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Shared combinational adder outside the arbiter.
  assign {adder_carry, adder_ans} = {1'b0, adder_opr1} + {1'b0, adder_opr2};

  adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opr1    (req_opr1),
    .req_opr2    (req_opr2),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_ans    (resp_ans),
    .resp_carry  (resp_carry),
    .adder_opr1  (adder_opr1),
    .adder_opr2  (adder_opr2),
    .adder_ans   (adder_ans),
    .adder_carry (adder_carry),
    .grant_count (grant_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    rst       = 1'b1;
    req_valid = '0;
    req_opr1  = '0;
    req_opr2  = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ready",   32'(req_ready),   32'h0);
    chk("rst_rvalid",  32'(resp_valid),  32'h0);
    chk("rst_id",      32'(resp_id),     32'h0);
    chk("rst_ans",     32'(resp_ans),    32'h0);
    chk("rst_carry",   32'(resp_carry),  32'h0);
    chk("rst_opr1",    32'(adder_opr1),  32'h0);
    chk("rst_count",   grant_count,      32'h0);

    // Single request from requester 0
    rst = 1'b0;
    req_valid = 4'b0001;
    req_opr1[0*WIDTH +: WIDTH] = 16'h1234;
    req_opr2[0*WIDTH +: WIDTH] = 16'h0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_calc_ready", 32'(req_ready),  32'h0);
    chk("t1_calc_opr1",  32'(adder_opr1), 32'h1234);
    chk("t1_calc_opr2",  32'(adder_opr2), 32'h0001);
    chk("t1_calc_rv",    32'(resp_valid), 32'h0);
    tick();
    chk("t1_rv",    32'(resp_valid), 32'h1);
    chk("t1_ans",   32'(resp_ans),   32'h1235);
    chk("t1_carry", 32'(resp_carry), 32'h0);
    chk("t1_id",    32'(resp_id),    32'h0);
    tick();
    chk("t1_rv_clr",   32'(resp_valid), 32'h0);
    chk("t1_ans_hold", 32'(resp_ans),   32'h1235);
    chk("t1_opr_hold", 32'(adder_opr1), 32'h1234);

    // Overflow from requester 2
    req_valid = 4'b0100;
    req_opr1[2*WIDTH +: WIDTH] = 16'hFFFF;
    req_opr2[2*WIDTH +: WIDTH] = 16'h0001;
    #1;
    chk("ovf_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    chk("ovf_rv",    32'(resp_valid), 32'h4);
    chk("ovf_ans",   32'(resp_ans),   32'h0000);
    chk("ovf_carry", 32'(resp_carry), 32'h1);
    chk("ovf_id",    32'(resp_id),    32'h2);
    tick();

    // Skip and wrap: last grant 2, requesters 1 and 3 held valid
    req_valid = 4'b1010;
    req_opr1[1*WIDTH +: WIDTH] = 16'h7FFF;
    req_opr2[1*WIDTH +: WIDTH] = 16'h0001;
    req_opr1[3*WIDTH +: WIDTH] = 16'h00FF;
    req_opr2[3*WIDTH +: WIDTH] = 16'h0001;
    #1;
    chk("sw_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("sw_wait_ready", 32'(req_ready), 32'h0);
    tick();
    chk("sw_rv3",  32'(resp_valid), 32'h8);
    chk("sw_id3",  32'(resp_id),    32'h3);
    chk("sw_ans3", 32'(resp_ans),   32'h0100);
    tick();
    chk("sw_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    chk("sw_rv1",    32'(resp_valid), 32'h2);
    chk("sw_id1",    32'(resp_id),    32'h1);
    chk("sw_ans1",   32'(resp_ans),   32'h8000);
    chk("sw_carry1", 32'(resp_carry), 32'h0);
    tick();
    chk("pre_rst_count", grant_count, STATS ? 32'd4 : 32'd0);

    // Reset asserted mid-transaction (during CALC)
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #1;
    chk("mid_in_calc_opr1", 32'(adder_opr1), 32'hFFFF);
    rst = 1'b1;
    #1;
    chk("mid_opr1",  32'(adder_opr1), 32'h0);
    chk("mid_ans",   32'(resp_ans),   32'h0);
    chk("mid_count", grant_count,     32'h0);
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_opr1[i*WIDTH +: WIDTH] = 16'(16'h1000 * (i + 1));
      req_opr2[i*WIDTH +: WIDTH] = 16'(i);
    end
    #1;
    chk("mid_ready_in_rst", 32'(req_ready), 32'h0);
    tick();
    chk("mid_rv_after_edge", 32'(resp_valid), 32'h0);
    tick();
    chk("mid_rv_after_edge2", 32'(resp_valid), 32'h0);

    // Fairness: all four held continuously from reset release
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      g = k % NUM_REQ;
      chk("fair_count", grant_count,     STATS ? 32'(k) : 32'd0);
      chk("fair_ready", 32'(req_ready),  32'(1 << g));
      chk("fair_idle_rv", 32'(resp_valid), 32'h0);
      tick();
      chk("fair_calc_opr1", 32'(adder_opr1), 32'(16'h1000 * (g + 1)));
      chk("fair_calc_rv",   32'(resp_valid), 32'h0);
      tick();
      chk("fair_rv",  32'(resp_valid), 32'(1 << g));
      chk("fair_id",  32'(resp_id),    32'(g));
      chk("fair_ans", 32'(resp_ans),   32'(16'h1000 * (g + 1) + g));
      tick();
    end
    req_valid = '0;
    chk("final_count", grant_count, STATS ? 32'd6 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
